fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | fetch_unit : PC register and IF/ID stage feeding a combinational instruction ROM
// | Rev 1.0
// +-----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q,       pc_d;
   logic [31:0] id_pc_q,    id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] count_q,    count_d;

   // Redirect outranks stall; the PC and counter both wrap naturally at 2^32.
   always_comb begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      count_d    = count_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         id_pc_d    = 32'h0000_0000;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
      end else if (!stall) begin
         pc_d       = pc_q + 32'd4;
         id_pc_d    = pc_q;
         id_instr_d = imem_instr;
         id_valid_d = 1'b1;
         count_d    = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         id_pc_q    <= 32'h0000_0000;
         id_instr_q <= NOP_INSTR;
         id_valid_q <= 1'b0;
         count_q    <= 32'h0000_0000;
      end else begin
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign id_pc       = id_pc_q;
   assign id_instr    = id_instr_q;
   assign id_valid    = id_valid_q;
   assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_fetch_unit : directed bench for fetch_unit with a reference model and literal checks
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference state: what the pipeline front end must hold after each edge.
   logic [31:0] m_pc, m_id_pc, m_id_instr, m_cnt;
   logic        m_valid;

   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_valid       (id_valid),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'd0:   rom = 32'h0010_0093;
         32'd4:   rom = 32'h0020_0113;
         32'd8:   rom = 32'h0020_81B3;
         32'd12:  rom = 32'h0000_0013;
         default: rom = {a[15:0], ~a[15:0]};
      endcase
   endfunction

   always_comb imem_instr = rom(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_addr",   imem_addr,   m_pc);
         check("id_pc",       id_pc,       m_id_pc);
         check("id_instr",    id_instr,    m_id_instr);
         check("id_valid",    {31'd0, id_valid}, {31'd0, m_valid});
         check("fetch_count", fetch_count, m_cnt);
      end
   end

   // One rising edge: advance the model from the inputs in force, then settle.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         m_pc = RESET_PC; m_id_pc = 0; m_id_instr = NOP_INSTR; m_valid = 0; m_cnt = 0;
      end else if (redirect_valid) begin
         m_pc = redirect_pc & ~32'd3; m_id_pc = 0; m_id_instr = NOP_INSTR; m_valid = 0;
      end else if (!stall) begin
         m_id_pc = m_pc; m_id_instr = rom(m_pc); m_valid = 1; m_cnt = m_cnt + 1;
         m_pc = m_pc + 4;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1; stall = 0; redirect_valid = 0;
      step();
      rst = 0;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check("rst_addr",  imem_addr,   32'h0);
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_instr", id_instr,    32'h0000_0013);
      check("rst_count", fetch_count, 32'd0);

      // Free-running fetch from the program ROM.
      repeat (4) step();
      check("run_addr",  imem_addr,   32'd16);
      check("run_instr", id_instr,    32'h0000_0013);
      check("run_count", fetch_count, 32'd4);
      check("run_idpc",  id_pc,       32'd12);

      // Two-cycle stall while fetching address 8.
      do_reset();
      repeat (2) step();
      stall = 1;
      repeat (2) step();
      check("stall_addr",  imem_addr,   32'd8);
      check("stall_instr", id_instr,    32'h0020_0113);
      check("stall_count", fetch_count, 32'd2);
      stall = 0;
      step();
      check("unstall_instr", id_instr, 32'h0020_81B3);

      // Redirect back to 4 while at 12.
      check("pre_redir_addr", imem_addr, 32'd12);
      redirect_valid = 1; redirect_pc = 32'h4;
      step();
      check("redir_addr",  imem_addr, 32'd4);
      check("redir_valid", {31'd0, id_valid}, 32'd0);
      check("redir_instr", id_instr,  32'h0000_0013);
      check("redir_count", fetch_count, 32'd3);
      redirect_valid = 0;
      step();
      check("post_redir_instr", id_instr, 32'h0020_0113);
      check("post_redir_pc",    id_pc,    32'd4);

      // Redirect beats stall; misaligned target gets its low bits cleared.
      redirect_valid = 1; stall = 1; redirect_pc = 32'h0000_000B;
      step();
      check("rs_addr",  imem_addr, 32'd8);
      check("rs_valid", {31'd0, id_valid}, 32'd0);
      check("rs_instr", id_instr,  32'h0000_0013);
      redirect_valid = 0; stall = 0;
      step();

      // Address wrap at the top of memory.
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 0;
      step();
      check("wrap_addr",  imem_addr, 32'h0);
      check("wrap_idpc",  id_pc,     32'hFFFF_FFFC);
      check("wrap_instr", id_instr,  32'hFFFC_0003);

      // Mixed stall / redirect pattern, checked by the model every cycle.
      for (int i = 0; i < 24; i++) begin
         stall          = (i % 3 == 1);
         redirect_valid = (i % 7 == 5);
         redirect_pc    = 32'h100 + 32'(i * 6);
         step();
      end
      stall = 0; redirect_valid = 0;
      repeat (2) step();

      // Reset mid-stream overrides stall and redirect.
      rst = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h40;
      step();
      check("mrst_addr",  imem_addr,   RESET_PC);
      check("mrst_valid", {31'd0, id_valid}, 32'd0);
      check("mrst_instr", id_instr,    32'h0000_0013);
      check("mrst_count", fetch_count, 32'd0);
      rst = 0; stall = 0; redirect_valid = 0;
      step();
      check("resume_valid", {31'd0, id_valid}, 32'd1);
      check("resume_instr", id_instr,  32'h0010_0093);
      check("resume_addr",  imem_addr, 32'd4);
      check("resume_count", fetch_count, 32'd1);

      @(posedge clk);
      chk_en = 1'b0;
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
